// File: rtl/keyboard_event_tracker_if.sv
`default_nettype none
// ============================================================================
// Module   : keyboard_event_tracker_if
// Purpose  : Scan-byte input, key lookup and event-FIFO pop bus of the tracker
// Revision : 1.0 - initial release
// ============================================================================
interface keyboard_event_tracker_if #(
    parameter int FIFO_DEPTH = 8
) ();
    localparam int c_cnt_w = $clog2(FIFO_DEPTH) + 1;

    logic [7:0]         byte_in;
    logic               byte_valid;
    logic [8:0]         query_addr;
    logic               query_pressed;
    logic               any_pressed;
    logic               evt_valid;
    logic [9:0]         evt_data;
    logic               evt_ready;
    logic [c_cnt_w-1:0] evt_count;
    logic               overflow;
    logic               clear_overflow;

    // Producer/consumer side: feeds scan bytes, queries keys, pops events
    modport master (
        output byte_in, byte_valid, query_addr, evt_ready, clear_overflow,
        input  query_pressed, any_pressed, evt_valid, evt_data, evt_count, overflow
    );

    modport slave (
        input  byte_in, byte_valid, query_addr, evt_ready, clear_overflow,
        output query_pressed, any_pressed, evt_valid, evt_data, evt_count, overflow
    );
endinterface
`default_nettype wire

// File: rtl/keyboard_event_tracker.sv
`default_nettype none
// ============================================================================
// Module   : keyboard_event_tracker
// Purpose  : PS/2 make/break/E0/E1 decoder, 512-key pressed bitmap, FWFT event FIFO
// Revision : 1.0 - initial release
// ============================================================================
module keyboard_event_tracker #(
    parameter int FIFO_DEPTH    = 8,
    parameter int REPEAT_FILTER = 1,
    parameter int CLEAR_ON_BAT  = 1
) (
    input  wire logic               clk,
    input  wire logic               rst,
    keyboard_event_tracker_if.slave bus
);
    localparam int c_aw = $clog2(FIFO_DEPTH);
    localparam int c_cw = $clog2(FIFO_DEPTH) + 1;

    localparam logic [2:0] c_st_idle    = 3'd0;
    localparam logic [2:0] c_st_ext     = 3'd1;
    localparam logic [2:0] c_st_brk     = 3'd2;
    localparam logic [2:0] c_st_ext_brk = 3'd3;
    localparam logic [2:0] c_st_pause   = 3'd4;

    localparam logic [7:0] c_b_ext   = 8'hE0;
    localparam logic [7:0] c_b_brk   = 8'hF0;
    localparam logic [7:0] c_b_pause = 8'hE1;
    localparam logic [7:0] c_b_bat   = 8'hAA;
    localparam logic [7:0] c_b_ovr0  = 8'h00;
    localparam logic [7:0] c_b_ovr1  = 8'hFF;

    localparam logic [2:0] c_pause_last = 3'd6;
    localparam logic [9:0] c_pause_evt  = {1'b0, 1'b1, 8'h77};

    logic [2:0]      state_q, state_d;
    logic [2:0]      pause_cnt_q, pause_cnt_d;
    logic [511:0]    bitmap_q, bitmap_d;
    logic            query_pressed_q, query_pressed_d;
    logic            any_pressed_q, any_pressed_d;
    logic [c_aw-1:0] wr_ptr_q, wr_ptr_d;
    logic [c_aw-1:0] rd_ptr_q, rd_ptr_d;
    logic [c_cw-1:0] count_q, count_d;
    logic            overflow_q, overflow_d;
    logic [9:0]      fifo_mem_q [FIFO_DEPTH];

    logic       w_is_ext, w_is_brk, w_is_pause, w_is_bat_clr, w_is_ovr;
    logic       w_make, w_break, w_bat_clear, w_pause_done, w_key_ext;
    logic [8:0] w_key_idx;
    logic       w_push;
    logic [9:0] w_push_data;
    logic       w_empty, w_full, w_pop, w_wr_en, w_drop;

    assign w_is_ext     = (bus.byte_in == c_b_ext);
    assign w_is_brk     = (bus.byte_in == c_b_brk);
    assign w_is_pause   = (bus.byte_in == c_b_pause);
    assign w_is_bat_clr = (bus.byte_in == c_b_bat) && (CLEAR_ON_BAT != 0);
    assign w_is_ovr     = (bus.byte_in == c_b_ovr0) || (bus.byte_in == c_b_ovr1);

    // ------------------------------------------------------------------
    // Decoder FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= c_st_idle;
            pause_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            pause_cnt_q <= pause_cnt_d;
        end
    end

    // Decoder FSM: next state
    always_comb begin
        state_d     = state_q;
        pause_cnt_d = pause_cnt_q;
        if (bus.byte_valid) begin
            case (state_q)
                c_st_idle: begin
                    if (w_is_ext) begin
                        state_d = c_st_ext;
                    end else if (w_is_brk) begin
                        state_d = c_st_brk;
                    end else if (w_is_pause) begin
                        state_d     = c_st_pause;
                        pause_cnt_d = '0;
                    end
                end
                c_st_ext: begin
                    if (w_is_brk) begin
                        state_d = c_st_ext_brk;
                    end else if (!w_is_ext) begin
                        state_d = c_st_idle;
                    end
                end
                c_st_brk, c_st_ext_brk: state_d = c_st_idle;
                c_st_pause: begin
                    if (pause_cnt_q == c_pause_last) begin
                        state_d     = c_st_idle;
                        pause_cnt_d = '0;
                    end else begin
                        pause_cnt_d = pause_cnt_q + 3'd1;
                    end
                end
                default: state_d = c_st_idle;
            endcase
        end
    end

    // Decoder FSM: per-byte actions
    always_comb begin
        w_make       = 1'b0;
        w_break      = 1'b0;
        w_bat_clear  = 1'b0;
        w_pause_done = 1'b0;
        w_key_ext    = 1'b0;
        if (bus.byte_valid) begin
            case (state_q)
                c_st_idle: begin
                    if (w_is_bat_clr) begin
                        w_bat_clear = 1'b1;
                    end else if (!(w_is_ext || w_is_brk || w_is_pause || w_is_ovr)) begin
                        w_make = 1'b1;
                    end
                end
                c_st_ext: begin
                    if (!(w_is_brk || w_is_ext)) begin
                        w_make    = 1'b1;
                        w_key_ext = 1'b1;
                    end
                end
                c_st_brk: w_break = 1'b1;
                c_st_ext_brk: begin
                    w_break   = 1'b1;
                    w_key_ext = 1'b1;
                end
                c_st_pause: w_pause_done = (pause_cnt_q == c_pause_last);
                default: ;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Bitmap update and event generation
    // ------------------------------------------------------------------
    assign w_key_idx = {w_key_ext, bus.byte_in};

    always_comb begin
        bitmap_d    = bitmap_q;
        w_push      = 1'b0;
        w_push_data = '0;
        if (w_bat_clear) begin
            bitmap_d = '0;
        end else if (w_make) begin
            bitmap_d[w_key_idx] = 1'b1;
            // Typematic repeats of a held key are optionally suppressed
            if (!((REPEAT_FILTER != 0) && bitmap_q[w_key_idx])) begin
                w_push      = 1'b1;
                w_push_data = {1'b0, w_key_idx};
            end
        end else if (w_break) begin
            bitmap_d[w_key_idx] = 1'b0;
            w_push              = 1'b1;
            w_push_data         = {1'b1, w_key_idx};
        end else if (w_pause_done) begin
            w_push      = 1'b1;
            w_push_data = c_pause_evt;
        end
    end

    // Lookups see the bitmap as it stood before this cycle's update
    assign query_pressed_d = bitmap_q[bus.query_addr];
    assign any_pressed_d   = |bitmap_q;

    // ------------------------------------------------------------------
    // Event FIFO (first-word-fall-through)
    // ------------------------------------------------------------------
    assign w_empty = (count_q == '0);
    assign w_full  = (count_q == c_cw'(FIFO_DEPTH));
    assign w_pop   = !w_empty && bus.evt_ready;
    assign w_wr_en = w_push && (!w_full || w_pop);
    assign w_drop  = w_push && w_full && !w_pop;

    always_comb begin
        wr_ptr_d   = w_wr_en ? wr_ptr_q + c_aw'(1) : wr_ptr_q;
        rd_ptr_d   = w_pop   ? rd_ptr_q + c_aw'(1) : rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        case ({w_wr_en, w_pop})
            2'b10:   count_d = count_q + c_cw'(1);
            2'b01:   count_d = count_q - c_cw'(1);
            default: count_d = count_q;
        endcase
        if (w_drop) begin
            overflow_d = 1'b1;
        end else if (bus.clear_overflow) begin
            overflow_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bitmap_q        <= '0;
            query_pressed_q <= 1'b0;
            any_pressed_q   <= 1'b0;
            wr_ptr_q        <= '0;
            rd_ptr_q        <= '0;
            count_q         <= '0;
            overflow_q      <= 1'b0;
        end else begin
            bitmap_q        <= bitmap_d;
            query_pressed_q <= query_pressed_d;
            any_pressed_q   <= any_pressed_d;
            wr_ptr_q        <= wr_ptr_d;
            rd_ptr_q        <= rd_ptr_d;
            count_q         <= count_d;
            overflow_q      <= overflow_d;
        end
    end

    // Storage needs no reset: the empty flag masks stale entries
    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            fifo_mem_q[wr_ptr_q] <= w_push_data;
        end
    end

    assign bus.query_pressed = query_pressed_q;
    assign bus.any_pressed   = any_pressed_q;
    assign bus.evt_valid     = !w_empty;
    assign bus.evt_data      = w_empty ? 10'd0 : fifo_mem_q[rd_ptr_q];
    assign bus.evt_count     = count_q;
    assign bus.overflow      = overflow_q;

endmodule
`default_nettype wire

// File: tb/tb_keyboard_event_tracker.sv
`default_nettype none
// ============================================================================
// Module   : tb_keyboard_event_tracker
// Purpose  : Two tracker configurations driven in lockstep against a queue model
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_keyboard_event_tracker;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic [7:0] s_byte = '0;
    logic       s_bv   = 1'b0;
    logic [8:0] s_qa   = '0;
    logic       s_rdy  = 1'b0;
    logic       s_clr  = 1'b0;

    keyboard_event_tracker_if #(.FIFO_DEPTH(8)) if0 ();
    keyboard_event_tracker_if #(.FIFO_DEPTH(4)) if1 ();

    assign if0.byte_in = s_byte;  assign if1.byte_in = s_byte;
    assign if0.byte_valid = s_bv; assign if1.byte_valid = s_bv;
    assign if0.query_addr = s_qa; assign if1.query_addr = s_qa;
    assign if0.evt_ready = s_rdy; assign if1.evt_ready = s_rdy;
    assign if0.clear_overflow = s_clr; assign if1.clear_overflow = s_clr;

    keyboard_event_tracker #(.FIFO_DEPTH(8), .REPEAT_FILTER(1), .CLEAR_ON_BAT(1)) u_dut0 (
        .clk(clk), .rst(rst), .bus(if0.slave));
    keyboard_event_tracker #(.FIFO_DEPTH(4), .REPEAT_FILTER(0), .CLEAR_ON_BAT(0)) u_dut1 (
        .clk(clk), .rst(rst), .bus(if1.slave));

    // Reference model: key set, pending-prefix flags and event queues
    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;
    bit          pressed [2][512];
    bit          m_ext [2];
    bit          m_brk [2];
    int          m_pause [2];
    bit          m_ovf [2];
    bit          exp_qp [2];
    bit          exp_any [2];
    logic [9:0]  q0 [$];
    logic [9:0]  q1 [$];
    int          depth [2] = '{8, 4};
    bit          rf [2]    = '{1'b1, 1'b0};
    bit          cob [2]   = '{1'b1, 1'b0};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    function automatic int qsize(input int k);
        return (k == 0) ? q0.size() : q1.size();
    endfunction

    function automatic logic [9:0] qhead(input int k);
        if (qsize(k) == 0) return 10'd0;
        return (k == 0) ? q0[0] : q1[0];
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < 512; i++) pressed[k][i] = 1'b0;
            m_ext[k] = 1'b0; m_brk[k] = 1'b0; m_pause[k] = 0; m_ovf[k] = 1'b0;
        end
        q0.delete();
        q1.delete();
    endtask

    task automatic decode(input int k, input logic [7:0] b, output bit ev, output logic [9:0] ed);
        logic [8:0] idx;
        ev = 1'b0;
        ed = '0;
        if (m_pause[k] > 0) begin
            m_pause[k]--;
            if (m_pause[k] == 0) begin ev = 1'b1; ed = 10'h177; end
        end else if (m_brk[k]) begin
            idx = {m_ext[k], b};
            pressed[k][idx] = 1'b0;
            ev = 1'b1; ed = {1'b1, idx};
            m_brk[k] = 1'b0; m_ext[k] = 1'b0;
        end else if (m_ext[k] && b == 8'hF0) begin
            m_brk[k] = 1'b1;
        end else if (m_ext[k] && b == 8'hE0) begin
            m_ext[k] = 1'b1;
        end else if (!m_ext[k] && b == 8'hE0) begin
            m_ext[k] = 1'b1;
        end else if (!m_ext[k] && b == 8'hF0) begin
            m_brk[k] = 1'b1;
        end else if (!m_ext[k] && b == 8'hE1) begin
            m_pause[k] = 7;
        end else if (!m_ext[k] && b == 8'hAA && cob[k]) begin
            for (int i = 0; i < 512; i++) pressed[k][i] = 1'b0;
        end else if (!m_ext[k] && (b == 8'h00 || b == 8'hFF)) begin
            ev = 1'b0;
        end else begin
            idx = {m_ext[k], b};
            ev  = !(rf[k] && pressed[k][idx]);
            ed  = {1'b0, idx};
            pressed[k][idx] = 1'b1;
            m_ext[k] = 1'b0;
        end
    endtask

    task automatic model_cycle(input int k);
        bit         ev, pop, full, anyp;
        logic [9:0] ed;
        anyp = 1'b0;
        for (int i = 0; i < 512; i++) anyp |= pressed[k][i];
        exp_qp[k]  = pressed[k][s_qa];
        exp_any[k] = anyp;
        ev = 1'b0;
        ed = '0;
        if (s_bv) decode(k, s_byte, ev, ed);
        pop  = (qsize(k) > 0) && s_rdy;
        full = (qsize(k) == depth[k]);
        if (pop) begin
            if (k == 0) q0.delete(0); else q1.delete(0);
        end
        if (ev && (!full || pop)) begin
            if (k == 0) q0.push_back(ed); else q1.push_back(ed);
        end
        if (ev && full && !pop) m_ovf[k] = 1'b1;
        else if (s_clr)         m_ovf[k] = 1'b0;
    endtask

    task automatic cmp_inst(input string p, input int k, input logic vld, input logic [9:0] dat,
                            input logic [6:0] cnt, input logic ovf, input logic qp, input logic anyp);
        check({p, ".evt_valid"},     32'(vld),  32'(qsize(k) > 0));
        check({p, ".evt_data"},      32'(dat),  32'(qhead(k)));
        check({p, ".evt_count"},     32'(cnt),  32'(qsize(k)));
        check({p, ".overflow"},      32'(ovf),  32'(m_ovf[k]));
        check({p, ".query_pressed"}, 32'(qp),   32'(exp_qp[k]));
        check({p, ".any_pressed"},   32'(anyp), 32'(exp_any[k]));
    endtask

    task automatic step(input bit bv, input logic [7:0] b, input logic [8:0] qa, input bit rdy, input bit clr);
        @(negedge clk);
        s_bv = bv; s_byte = b; s_qa = qa; s_rdy = rdy; s_clr = clr;
        model_cycle(0);
        model_cycle(1);
        @(posedge clk);
        #1;
        cmp_inst("d0", 0, if0.evt_valid, if0.evt_data, 7'(if0.evt_count), if0.overflow,
                 if0.query_pressed, if0.any_pressed);
        cmp_inst("d1", 1, if1.evt_valid, if1.evt_data, 7'(if1.evt_count), if1.overflow,
                 if1.query_pressed, if1.any_pressed);
    endtask

    task automatic idle(input int n, input logic [8:0] qa, input bit rdy);
        for (int i = 0; i < n; i++) step(1'b0, 8'h00, qa, rdy, 1'b0);
    endtask

    task automatic send(input logic [7:0] b, input logic [8:0] qa);
        step(1'b1, b, qa, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        s_bv = 1'b0; s_rdy = 1'b0; s_clr = 1'b0;
        #1;
        model_reset();
        check("rst.d0.evt_valid", 32'(if0.evt_valid), 32'd0);
        check("rst.d0.evt_data",  32'(if0.evt_data),  32'd0);
        check("rst.d0.evt_count", 32'(if0.evt_count), 32'd0);
        check("rst.d0.overflow",  32'(if0.overflow),  32'd0);
        check("rst.d0.query",     32'(if0.query_pressed), 32'd0);
        check("rst.d0.any",       32'(if0.any_pressed),   32'd0);
        check("rst.d1.evt_count", 32'(if1.evt_count), 32'd0);
        check("rst.d1.any",       32'(if1.any_pressed),   32'd0);
        @(negedge clk);
        rst = 1'b1;
    endtask

    function automatic logic [7:0] rand_byte();
        logic [7:0] pool [8] = '{8'h1C, 8'h75, 8'h14, 8'h77, 8'h23, 8'h2B, 8'h5A, 8'h12};
        int r = $urandom_range(0, 99);
        if (r < 10) return 8'hE0;
        if (r < 20) return 8'hF0;
        if (r < 23) return 8'hE1;
        if (r < 25) return 8'hAA;
        if (r < 27) return 8'h00;
        if (r < 29) return 8'hFF;
        if (r < 85) return pool[$urandom_range(0, 7)];
        return 8'($urandom_range(1, 254));
    endfunction

    function automatic logic [8:0] rand_qa();
        logic [8:0] pool [8] = '{9'h01C, 9'h175, 9'h075, 9'h014, 9'h177, 9'h05A, 9'h11C, 9'h012};
        if ($urandom_range(0, 9) < 7) return pool[$urandom_range(0, 7)];
        return 9'($urandom_range(0, 511));
    endfunction

    initial begin
        int rdy_pct;
        model_reset();
        do_reset();

        // Make then break of a plain key
        send(8'h1C, 9'h01C);
        idle(1, 9'h01C, 1'b0);
        check("t1.query_after_make", 32'(if0.query_pressed), 32'd1);
        send(8'hF0, 9'h01C);
        send(8'h1C, 9'h01C);
        idle(2, 9'h01C, 1'b0);
        check("t1.query_after_break", 32'(if0.query_pressed), 32'd0);
        check("t1.count", 32'(if0.evt_count), 32'd2);
        check("t1.head",  32'(if0.evt_data),  32'h01C);
        idle(12, 9'h01C, 1'b1);

        // Extended make/break
        send(8'hE0, 9'h175);
        send(8'h75, 9'h175);
        idle(1, 9'h175, 1'b0);
        check("t2.query_ext", 32'(if0.query_pressed), 32'd1);
        check("t2.head_make", 32'(if0.evt_data), 32'h175);
        idle(1, 9'h075, 1'b0);
        check("t2.query_plain", 32'(if0.query_pressed), 32'd0);
        send(8'hE0, 9'h175);
        send(8'hF0, 9'h175);
        send(8'h75, 9'h175);
        idle(2, 9'h175, 1'b0);
        check("t2.query_released", 32'(if0.query_pressed), 32'd0);
        idle(12, 9'h175, 1'b1);

        // Typematic repeat filtering
        send(8'h1C, 9'h01C); send(8'h1C, 9'h01C); send(8'h1C, 9'h01C);
        send(8'hF0, 9'h01C); send(8'h1C, 9'h01C);
        idle(1, 9'h01C, 1'b0);
        check("t3.filtered_count",   32'(if0.evt_count), 32'd2);
        check("t3.unfiltered_count", 32'(if1.evt_count), 32'd4);
        idle(12, 9'h01C, 1'b1);

        // Overflow, simultaneous push/pop while full, set-over-clear priority
        for (int i = 0; i < 9; i++) send(8'h30 + 8'(i), 9'h030);
        check("t4.count_full", 32'(if0.evt_count), 32'd8);
        check("t4.overflow",   32'(if0.overflow),  32'd1);
        check("t4.d1_count",   32'(if1.evt_count), 32'd4);
        step(1'b1, 8'h40, 9'h030, 1'b1, 1'b0);
        check("t4.pushpop_count", 32'(if0.evt_count), 32'd8);
        check("t4.pushpop_head",  32'(if0.evt_data),  32'h031);
        step(1'b1, 8'h41, 9'h030, 1'b0, 1'b1);
        check("t4.set_beats_clear", 32'(if0.overflow), 32'd1);
        step(1'b0, 8'h00, 9'h030, 1'b0, 1'b1);
        check("t4.cleared", 32'(if0.overflow), 32'd0);
        idle(12, 9'h030, 1'b1);

        // Pause sequence
        send(8'hE1, 9'h014); send(8'h14, 9'h014); send(8'h77, 9'h014); send(8'hE1, 9'h014);
        send(8'hF0, 9'h014); send(8'h14, 9'h014); send(8'hF0, 9'h014); send(8'h77, 9'h014);
        idle(1, 9'h014, 1'b0);
        check("t5.count", 32'(if0.evt_count), 32'd1);
        check("t5.head",  32'(if0.evt_data),  32'h177);
        check("t5.q014",  32'(if0.query_pressed), 32'd0);
        idle(1, 9'h177, 1'b0);
        check("t5.q177",  32'(if0.query_pressed), 32'd0);
        send(8'h5A, 9'h05A);
        idle(1, 9'h05A, 1'b0);
        check("t5.idle_after", 32'(if0.query_pressed), 32'd1);
        idle(12, 9'h05A, 1'b1);

        // Self-test byte clears held keys
        send(8'h1C, 9'h01C); send(8'h23, 9'h01C); send(8'h2B, 9'h01C);
        check("t6.count_before", 32'(if0.evt_count), 32'd3);
        send(8'hAA, 9'h01C);
        idle(1, 9'h01C, 1'b0);
        check("t6.any_cleared", 32'(if0.any_pressed), 32'd0);
        check("t6.no_event",    32'(if0.evt_count),   32'd3);
        idle(12, 9'h01C, 1'b1);

        // Reset in the middle of an E0 prefix
        send(8'hE0, 9'h01C);
        do_reset();
        send(8'h1C, 9'h01C);
        idle(1, 9'h01C, 1'b0);
        check("t7.plain_code", 32'(if0.evt_data), 32'h01C);
        check("t7.query",      32'(if0.query_pressed), 32'd1);

        // Randomized traffic
        rdy_pct = 20;
        for (int c = 0; c < 4000; c++) begin
            if (c % 500 == 0) rdy_pct = (rdy_pct == 20) ? 70 : 20;
            if (c == 1500 || c == 3000) do_reset();
            step($urandom_range(0, 9) < 6, rand_byte(), rand_qa(),
                 $urandom_range(0, 99) < rdy_pct, $urandom_range(0, 99) < 3);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
`default_nettype wire
